// File: rtl/hotcache_pkg.sv
// Shared definitions for the bank access controller: FSM state encoding,
// timeout defaults and small helpers for picking the selected bank's signals.
package hotcache_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } bac_state_t;

    localparam int unsigned TIMEOUT_DEFAULT = 15;
    localparam int unsigned CNT_W           = 4;

    function automatic logic pickAck(input logic sel, input logic ack0, input logic ack1);
        return sel ? ack1 : ack0;
    endfunction

    function automatic logic [7:0] pickRdata(input logic sel, input logic [7:0] rdata0,
                                             input logic [7:0] rdata1);
        return sel ? rdata1 : rdata0;
    endfunction

endpackage

// File: rtl/chip_select_splitter.sv
// Splits a captured bank address into chip select, bank-local address and
// per-bank access strobes.
module chip_select_splitter (
    input  logic [0:7] i_addr,
    input  logic       i_strobe,
    output logic       o_chip_sel,
    output logic [0:6] o_local_addr,
    output logic       o_bank0_en,
    output logic       o_bank1_en
);

    assign o_chip_sel   = i_addr[7];
    assign o_local_addr = i_addr[0:6];
    assign o_bank0_en   = i_strobe & ~i_addr[7];
    assign o_bank1_en   = i_strobe &  i_addr[7];

endmodule

// File: rtl/bank_access_controller.sv
// Single-outstanding request/response bridge onto two memory banks sharing one
// bus, with a bounded wait for the selected bank's acknowledge.
module bank_access_controller
    import hotcache_pkg::*;
#(
    parameter int unsigned TIMEOUT = TIMEOUT_DEFAULT
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       req_valid,
    output logic       req_ready,
    input  logic [0:7] req_addr,
    input  logic       req_we,
    input  logic [7:0] req_wdata,
    output logic       resp_valid,
    input  logic       resp_ready,
    output logic [7:0] resp_rdata,
    output logic       resp_err,
    output logic       bank0_en,
    output logic       bank1_en,
    output logic       bank_we,
    output logic [0:6] bank_addr,
    output logic [7:0] bank_wdata,
    input  logic       bank0_ack,
    input  logic       bank1_ack,
    input  logic [7:0] bank0_rdata,
    input  logic [7:0] bank1_rdata
);

    localparam logic [CNT_W-1:0] LAST_WAIT = CNT_W'(TIMEOUT - 1);

    bac_state_t       r_state;
    logic [CNT_W-1:0] r_count;
    logic             r_reqReady;
    logic             r_respValid;
    logic             r_respErr;
    logic [7:0]       r_respRdata;
    logic             r_issue;
    logic [0:7]       r_addr;
    logic             r_we;
    logic [7:0]       r_wdata;

    logic             w_chipSel;
    logic             w_selAck;
    logic [7:0]       w_selRdata;

    chip_select_splitter u_splitter (
        .i_addr       (r_addr),
        .i_strobe     (r_issue),
        .o_chip_sel   (w_chipSel),
        .o_local_addr (bank_addr),
        .o_bank0_en   (bank0_en),
        .o_bank1_en   (bank1_en)
    );

    assign w_selAck   = pickAck(w_chipSel, bank0_ack, bank1_ack);
    assign w_selRdata = pickRdata(w_chipSel, bank0_rdata, bank1_rdata);

    // The ack check precedes the timeout check so a last-cycle ack still completes normally.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_count     <= '0;
            r_reqReady  <= 1'b1;
            r_respValid <= 1'b0;
            r_respErr   <= 1'b0;
            r_respRdata <= 8'h00;
            r_issue     <= 1'b0;
            r_addr      <= '0;
            r_we        <= 1'b0;
            r_wdata     <= 8'h00;
        end else begin
            r_issue <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (req_valid) begin
                        r_addr     <= req_addr;
                        r_we       <= req_we;
                        r_wdata    <= req_wdata;
                        r_reqReady <= 1'b0;
                        r_issue    <= 1'b1;
                        r_state    <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    r_count <= '0;
                    r_state <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (w_selAck) begin
                        r_respRdata <= r_we ? 8'h00 : w_selRdata;
                        r_respErr   <= 1'b0;
                        r_respValid <= 1'b1;
                        r_state     <= ST_RESP;
                    end else if (r_count == LAST_WAIT) begin
                        r_count     <= r_count + CNT_W'(1);
                        r_respRdata <= 8'h00;
                        r_respErr   <= 1'b1;
                        r_respValid <= 1'b1;
                        r_state     <= ST_RESP;
                    end else begin
                        r_count <= r_count + CNT_W'(1);
                    end
                end
                ST_RESP: begin
                    if (resp_ready) begin
                        r_respValid <= 1'b0;
                        r_respErr   <= 1'b0;
                        r_respRdata <= 8'h00;
                        r_reqReady  <= 1'b1;
                        r_state     <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign req_ready  = r_reqReady;
    assign resp_valid = r_respValid;
    assign resp_err   = r_respErr;
    assign resp_rdata = r_respRdata;
    assign bank_we    = r_we;
    assign bank_wdata = r_wdata;

endmodule
